// File: rtl/lcd_pkg.sv
// Shared constants, state codes, opcode masks and the address-counter step helper
// for the HD44780-style character sink.
package lcd_pkg;

  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_END   = 7'h27;
  localparam logic [7:0] SPACE      = 8'h20;

  typedef logic [1:0] state_t;
  localparam state_t StIdle     = 2'd0;
  localparam state_t StBusyWait = 2'd1;
  localparam state_t StClear    = 2'd2;

  // An instruction matches when (data & mask) == value; decode runs from the top bit down.
  localparam logic [7:0] OpDdramMask = 8'h80, OpDdramVal = 8'h80;
  localparam logic [7:0] OpCgramMask = 8'hC0, OpCgramVal = 8'h40;
  localparam logic [7:0] OpFuncMask  = 8'hE0, OpFuncVal  = 8'h20;
  localparam logic [7:0] OpShiftMask = 8'hF0, OpShiftVal = 8'h10;
  localparam logic [7:0] OpDispMask  = 8'hF8, OpDispVal  = 8'h08;
  localparam logic [7:0] OpEntryMask = 8'hFC, OpEntryVal = 8'h04;
  localparam logic [7:0] OpHomeMask  = 8'hFE, OpHomeVal  = 8'h02;
  localparam logic [7:0] OpClearMask = 8'hFF, OpClearVal = 8'h01;

  function automatic logic op_match(input logic [7:0] d, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (d & mask) == val;
  endfunction

  // Steps the address counter through the two 40-cell lines as one 80-cell ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == LINE_END)                   nxt = LINE2_BASE;
      else if (ac == LINE2_BASE + LINE_END) nxt = 7'h00;
      else                                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)           nxt = LINE2_BASE + LINE_END;
      else if (ac == LINE2_BASE) nxt = LINE_END;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_char_sink_if.sv
// 8-bit LCD bus between a display controller (master) and the character sink (slave).
interface lcd_char_sink_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic [7:0] LCD_DOUT;
  logic       BUSY;

  modport master (output LCD_EN, LCD_RS, LCD_RW, LCD_DATA, input LCD_DOUT, BUSY);
  modport slave  (input LCD_EN, LCD_RS, LCD_RW, LCD_DATA, output LCD_DOUT, BUSY);
endinterface

// File: rtl/lcd_ddram_bank.sv
// One DDRAM line: synchronous write port and a registered read port (read-before-write).
module lcd_ddram_bank #(
  parameter int unsigned Depth = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_char_sink.sv
// Device end of an HD44780-style 8-bit bus: instruction decode, address counter,
// busy/clear FSM, sticky error flags and a registered 2x16 screen read port.
module lcd_char_sink
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 0,
  parameter int unsigned LINE_LEN    = 40
) (
  input  logic                  CLK,
  input  logic                  RESET,
  lcd_char_sink_if.slave        lcd,
  output logic [1:0]            ERR,
  output logic [2:0]            DISP_CTRL,
  output logic [2:0]            FUNC,
  output logic [6:0]            AC,
  input  logic [4:0]            RD_ADDR,
  output logic [7:0]            RD_DATA
);

  localparam int unsigned     CntW      = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad   = CntW'(BUSY_CYCLES);
  localparam logic [5:0]      SweepLast = 6'(LINE_LEN - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      sweep_q, sweep_d;
  logic [6:0]      ac_q, ac_d;
  logic            id_q, id_d;
  logic [2:0]      disp_q, disp_d;
  logic [2:0]      func_q, func_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      dout_q, dout_d;
  logic            rd_line_q;

  logic       busy, wr, wr_ok, dat_wr, ddram_ok;
  logic [7:0] d;
  logic       bank0_we, bank1_we;
  logic [5:0] bank_waddr;
  logic [7:0] bank_wdata;
  logic [7:0] rd0, rd1;

  assign busy     = (state_q != StIdle);
  assign d        = lcd.LCD_DATA;
  assign wr       = lcd.LCD_EN & ~lcd.LCD_RW;
  assign wr_ok    = wr & ~busy;
  assign dat_wr   = wr_ok & lcd.LCD_RS;
  assign ddram_ok = (d[6:0] <= LINE_END) ||
                    ((d[6:0] >= LINE2_BASE) && (d[6:0] <= LINE2_BASE + LINE_END));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep_d = sweep_q;
    ac_d    = ac_q;
    id_d    = id_q;
    disp_d  = disp_q;
    func_d  = func_q;
    err_d   = err_q;
    dout_d  = dout_q;

    if (wr && busy) err_d[0] = 1'b1;
    if (lcd.LCD_EN && lcd.LCD_RW && !lcd.LCD_RS) dout_d = {busy, ac_q};

    case (state_q)
      StBusyWait: begin
        if (cnt_q == CntW'(1)) state_d = StIdle;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StClear: begin
        if (sweep_q == SweepLast) state_d = StIdle;
        else                      sweep_d = sweep_q + 6'd1;
      end
      default: ;
    endcase

    if (wr_ok) begin
      if (BUSY_CYCLES != 0) begin
        state_d = StBusyWait;
        cnt_d   = CntLoad;
      end
      if (lcd.LCD_RS) begin
        ac_d = ac_step(ac_q, id_q);
      end else if (op_match(d, OpDdramMask, OpDdramVal)) begin
        if (ddram_ok) ac_d = d[6:0];
        else          err_d[1] = 1'b1;
      end else if (op_match(d, OpCgramMask, OpCgramVal)) begin
        // CGRAM is not modelled; the write only costs busy time.
      end else if (op_match(d, OpFuncMask, OpFuncVal)) begin
        func_d = d[4:2];
      end else if (op_match(d, OpShiftMask, OpShiftVal)) begin
        if (!d[3]) ac_d = ac_step(ac_q, d[2]);
      end else if (op_match(d, OpDispMask, OpDispVal)) begin
        disp_d = d[2:0];
      end else if (op_match(d, OpEntryMask, OpEntryVal)) begin
        id_d = d[1];
      end else if (op_match(d, OpHomeMask, OpHomeVal)) begin
        ac_d = '0;
      end else if (op_match(d, OpClearMask, OpClearVal)) begin
        ac_d    = '0;
        id_d    = 1'b1;
        state_d = StClear;
        sweep_d = '0;
      end
    end
  end

  // Sweep and data writes share the bank write port; data is only accepted in idle.
  always_comb begin
    bank_waddr = ac_q[5:0];
    bank_wdata = d;
    bank0_we   = dat_wr & ~ac_q[6];
    bank1_we   = dat_wr & ac_q[6];
    if (state_q == StClear) begin
      bank_waddr = sweep_q;
      bank_wdata = SPACE;
      bank0_we   = 1'b1;
      bank1_we   = 1'b1;
    end
    if (RESET) begin
      bank0_we = 1'b0;
      bank1_we = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      sweep_q   <= '0;
      ac_q      <= '0;
      id_q      <= 1'b1;
      disp_q    <= 3'b000;
      func_q    <= 3'b011;
      err_q     <= 2'b00;
      dout_q    <= 8'h00;
      rd_line_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sweep_q   <= sweep_d;
      ac_q      <= ac_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      func_q    <= func_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      rd_line_q <= RD_ADDR[4];
    end
  end

  lcd_ddram_bank #(
    .Depth(LINE_LEN)
  ) u_bank0 (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .we_i   (bank0_we),
    .waddr_i(bank_waddr),
    .wdata_i(bank_wdata),
    .raddr_i({2'b00, RD_ADDR[3:0]}),
    .rdata_o(rd0)
  );

  lcd_ddram_bank #(
    .Depth(LINE_LEN)
  ) u_bank1 (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .we_i   (bank1_we),
    .waddr_i(bank_waddr),
    .wdata_i(bank_wdata),
    .raddr_i({2'b00, RD_ADDR[3:0]}),
    .rdata_o(rd1)
  );

  assign lcd.LCD_DOUT = dout_q;
  assign lcd.BUSY     = busy;
  assign ERR          = err_q;
  assign DISP_CTRL    = disp_q;
  assign FUNC         = func_q;
  assign AC           = ac_q;
  assign RD_DATA      = rd_line_q ? rd1 : rd0;

endmodule

// File: tb/tb_lcd_char_sink.sv
// Randomised scoreboard bench for lcd_char_sink: two instances (BUSY_CYCLES 0 and 3) share
// one stimulus stream; a linear-address reference model predicts every cycle's outputs.
module tb_lcd_char_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rd_addr;
  logic [1:0] err0, err1;
  logic [2:0] disp0, disp1, func0, func1;
  logic [6:0] ac0, ac1;
  logic [7:0] rdd0, rdd1;

  lcd_char_sink_if bus0 ();
  lcd_char_sink_if bus1 ();

  lcd_char_sink #(.BUSY_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(rst), .lcd(bus0), .ERR(err0), .DISP_CTRL(disp0), .FUNC(func0),
    .AC(ac0), .RD_ADDR(rd_addr), .RD_DATA(rdd0)
  );

  lcd_char_sink #(.BUSY_CYCLES(3)) dut1 (
    .CLK(clk), .RESET(rst), .lcd(bus1), .ERR(err1), .DISP_CTRL(disp1), .FUNC(func1),
    .AC(ac1), .RD_ADDR(rd_addr), .RD_DATA(rdd1)
  );

  typedef struct {
    int due;
    int sel;
    int kind;
    int exp;
    int arg;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic drain_chk = 1'b0;
  logic drain_done = 1'b0;

  // Reference model state; a cell value of -1 means "contents unknown".
  int m_cell[2][40];
  int m_ac, m_id, m_func, m_disp, m_err, m_dout, m_busy_left, m_clearing;
  int bc, sel, rd_force;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int step_ac(int ac, int inc);
    int lin;
    lin = (ac / 64) * 40 + (ac % 64);
    lin = (inc != 0) ? (lin + 1) % 80 : (lin + 79) % 80;
    return (lin / 40) * 64 + (lin % 40);
  endfunction

  function automatic string kname(int k);
    case (k)
      0: return "busy";
      1: return "ac";
      2: return "err";
      3: return "func";
      4: return "disp_ctrl";
      5: return "rd_data";
      default: return "lcd_dout";
    endcase
  endfunction

  function automatic int actual(int s, int k);
    case (k)
      0: return (s != 0) ? int'(bus1.BUSY) : int'(bus0.BUSY);
      1: return (s != 0) ? int'(ac1) : int'(ac0);
      2: return (s != 0) ? int'(err1) : int'(err0);
      3: return (s != 0) ? int'(func1) : int'(func0);
      4: return (s != 0) ? int'(disp1) : int'(disp0);
      5: return (s != 0) ? int'(rdd1) : int'(rdd0);
      default: return (s != 0) ? int'(bus1.LCD_DOUT) : int'(bus0.LCD_DOUT);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    int   act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      c   = sbq.pop_front();
      act = actual(c.sel, c.kind);
      checks++;
      if (c.due != cyc || act != c.exp) begin
        errors++;
        $display("FAIL %s dut%0d cyc=%0d due=%0d arg=%0d got=0x%0h want=0x%0h",
                 kname(c.kind), c.sel, cyc, c.due, c.arg, act, c.exp);
      end
    end
    if (drain_chk && !drain_done) begin
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain got=%0d pending want=0", sbq.size());
      end
      drain_done = 1'b1;
    end
  end

  task automatic push(int kind, int exp, int arg);
    chk_t c;
    c = '{due: cyc + 1, sel: sel, kind: kind, exp: exp, arg: arg};
    sbq.push_back(c);
  endtask

  // One bus cycle: drive inputs, predict the post-edge outputs, advance to the next cycle.
  task automatic step(logic rst_v, logic en, logic rs, logic rw, logic [7:0] data);
    int busy_now, rcell, accepted, is_clear, msb, a, idx;
    rst = rst_v;
    bus0.LCD_EN = en;   bus1.LCD_EN = en;
    bus0.LCD_RS = rs;   bus1.LCD_RS = rs;
    bus0.LCD_RW = rw;   bus1.LCD_RW = rw;
    bus0.LCD_DATA = data; bus1.LCD_DATA = data;
    if (rd_force >= 0) rd_addr = 5'(rd_force);
    else               rd_addr = 5'($urandom_range(0, 31));

    busy_now = (m_busy_left > 0) ? 1 : 0;
    rcell    = m_cell[int'(rd_addr[4])][int'(rd_addr[3:0])];

    if (rst_v) begin
      push(5, 0, int'(rd_addr));
      m_ac = 0; m_id = 1; m_disp = 0; m_func = 3; m_err = 0; m_dout = 0;
      m_busy_left = 40; m_clearing = 1;
    end else begin
      if (rcell >= 0) push(5, rcell, int'(rd_addr));
      if (en && rw && !rs) m_dout = busy_now * 128 + m_ac;
      if (busy_now != 0 && m_clearing != 0) begin
        idx = 40 - m_busy_left;
        m_cell[0][idx] = 32;
        m_cell[1][idx] = 32;
      end
      accepted = 0;
      is_clear = 0;
      if (en && !rw) begin
        if (busy_now != 0) begin
          m_err = m_err | 1;
        end else begin
          accepted = 1;
          if (rs) begin
            m_cell[m_ac / 64][m_ac % 64] = int'(data);
            m_ac = step_ac(m_ac, m_id);
          end else begin
            msb = -1;
            for (int b = 7; b >= 0; b--) if (data[b] && msb < 0) msb = b;
            case (msb)
              7: begin
                a = int'(data) % 128;
                if (a <= 39 || (a >= 64 && a <= 103)) m_ac = a;
                else m_err = m_err | 2;
              end
              5: m_func = (int'(data) / 4) % 8;
              4: if (!data[3]) m_ac = step_ac(m_ac, int'(data[2]));
              3: m_disp = int'(data) % 8;
              2: m_id = int'(data[1]);
              1: m_ac = 0;
              0: begin m_ac = 0; m_id = 1; is_clear = 1; end
              default: ;
            endcase
          end
        end
      end
      if (accepted != 0) begin
        m_busy_left = (is_clear != 0) ? 40 : bc;
        m_clearing  = is_clear;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_clearing = 0;
      end
    end

    push(0, (m_busy_left > 0) ? 1 : 0, 0);
    push(1, m_ac, 0);
    push(2, m_err, 0);
    push(3, m_func, 0);
    push(4, m_disp, 0);
    push(6, m_dout, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic ins(logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic dat(logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic read_screen();
    for (int i = 0; i < 32; i++) begin
      rd_force = i;
      idle(1);
    end
    rd_force = -1;
  endtask

  task automatic forget_cells();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 40; c++) m_cell[l][c] = -1;
  endtask

  task automatic random_run(int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      else if (r < 40) dat(8'($urandom_range(32, 126)));
      else if (r < 50) ins(8'h80 | 8'($urandom_range(0, 127)));
      else if (r < 52) ins(8'h01);
      else if (r < 75) ins(8'($urandom_range(0, 127)));
      else if (r < 85) step(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
      else if (r < 90) step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      else             idle(1);
    end
  endtask

  initial begin
    string clock_str;
    rd_force = -1;
    sel = 0;
    bc  = 0;
    forget_cells();
    rst = 1'b0;
    rd_addr = '0;
    bus0.LCD_EN = 1'b0; bus0.LCD_RS = 1'b0; bus0.LCD_RW = 1'b0; bus0.LCD_DATA = '0;
    bus1.LCD_EN = 1'b0; bus1.LCD_RS = 1'b0; bus1.LCD_RW = 1'b0; bus1.LCD_DATA = '0;
    @(posedge clk);
    #1;

    // BUSY_CYCLES = 0 instance: reset sweep, init sequence, a row of text.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);
    ins(8'h38); ins(8'h0C); ins(8'h06); ins(8'h80);
    clock_str = "12:34:56";
    for (int i = 0; i < 8; i++) dat(clock_str[i]);
    for (int i = 0; i < 9; i++) begin
      rd_force = i;
      idle(1);
    end
    rd_force = -1;

    // Line wrap forward, then decrement wrap from cell 0, then an illegal address.
    ins(8'hA7); dat("A"); dat("B");
    ins(8'h04); ins(8'h80); dat("Z");
    ins(8'hB0); idle(2);
    ins(8'h06);

    random_run(400);

    // Clear of a full screen, with a write landing mid-sweep.
    idle(m_busy_left);
    ins(8'h06);
    ins(8'h80); for (int i = 0; i < 16; i++) dat("X");
    ins(8'hC0); for (int i = 0; i < 16; i++) dat("X");
    read_screen();
    ins(8'h01);
    idle(10);
    dat("Q");
    idle(32);
    read_screen();

    // BUSY_CYCLES = 3 instance.
    sel = 1;
    bc  = 3;
    forget_cells();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);
    ins(8'h0C);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    dat("a"); dat("b"); dat("c");
    idle(3);
    ins(8'h0C);
    dat("d"); dat("e"); dat("f"); dat("g");
    idle(4);

    random_run(400);

    // Reset while the clear sweep is at index 20.
    idle(m_busy_left);
    ins(8'h01);
    idle(20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);
    read_screen();

    @(posedge clk);
    @(posedge clk);
    drain_chk = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
